// File: rtl/nt_trigger_monitor_if.sv
// Trigger-monitor control/observe bundle.
// master drives en/clr/a/b/arm/blk/thresh; slave returns hit/cnt/state/alarm.
interface nt_trigger_monitor_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic [CH-1:0]    a;
  logic [CH-1:0]    b;
  logic [CH-1:0]    arm;
  logic [CH-1:0]    blk0;
  logic [CH-1:0]    blk1;
  logic [CNT_W-1:0] thresh;
  logic [CH-1:0]    hit;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic             alarm;

  modport master (
    output en, clr, a, b, arm,
    output blk0, blk1, thresh,
    input  hit, cnt, state, alarm
  );

  modport slave (
    input  en, clr, a, b, arm,
    input  blk0, blk1, thresh,
    output hit, cnt, state, alarm
  );
endinterface

// File: rtl/nt_trigger_monitor.sv
// Multi-channel trigger monitor: delayed pair/arm, per-channel hit, sticky alarm.
// Ports: CLK, RSTB (async active-low), bus (slave: controls in, hit/cnt/state/alarm out).
module nt_trigger_monitor #(
  parameter int CH    = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  nt_trigger_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ALERT = 2'd2
  } state_e;

  logic [CH-1:0]    g_dly_q [DEPTH];
  logic [CH-1:0]    g_dly_d [DEPTH];
  logic [CH-1:0]    a_dly_q [DEPTH];
  logic [CH-1:0]    a_dly_d [DEPTH];
  logic [CH-1:0]    hit_q;
  logic [CH-1:0]    hit_d;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             alarm_q;
  logic             alarm_d;
  logic             any_hit;
  logic             thr_hit;
  logic             cnt_max;

  always_comb begin
    g_dly_d[0] = bus.a & bus.b;
    a_dly_d[0] = bus.arm;
    for (int i = 1; i < DEPTH; i++) begin
      g_dly_d[i] = g_dly_q[i-1];
      a_dly_d[i] = a_dly_q[i-1];
    end
  end

  // Blocks act on the same edge hit registers; they are not delayed.
  assign hit_d = ~(bus.blk0 | bus.blk1)
               & a_dly_q[DEPTH-1]
               & ~g_dly_q[DEPTH-1];

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      for (int i = 0; i < DEPTH; i++) begin
        g_dly_q[i] <= '0;
        a_dly_q[i] <= '0;
      end
      hit_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        g_dly_q[i] <= g_dly_d[i];
        a_dly_q[i] <= a_dly_d[i];
      end
      hit_q <= hit_d;
    end
  end

  assign any_hit = |hit_q;
  assign cnt_max = &cnt_q;
  assign thr_hit = (bus.thresh != '0)
                && (cnt_q >= bus.thresh);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.en) state_d = COUNT;
      end
      COUNT: begin
        // Alarm check outranks leaving on en=0;
        // the count freezes on either exit.
        if (thr_hit) begin
          state_d = ALERT;
        end else if (!bus.en) begin
          state_d = IDLE;
        end else if (any_hit && !cnt_max) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ALERT: begin
        state_d = ALERT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign alarm_d = (state_d == ALERT);

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign bus.hit   = hit_q;
  assign bus.cnt   = cnt_q;
  assign bus.state = state_q;
  assign bus.alarm = alarm_q;

endmodule

// File: doc/nt_trigger_monitor.md
# nt_trigger_monitor

Parametrised, multi-channel trigger-condition monitor for the trojan-detection subcircuit set. Each channel delays a gated pair-condition and an arm signal through a DEPTH-stage flop line and combines them with two same-cycle block inputs into a registered per-channel hit. A shared saturating event counter and a three-state FSM raise a sticky alarm once the hit count reaches a programmable threshold.

## Interface
- CH, 4, number of independent channels (≥1)
- DEPTH, 2, delay-line stages for the pair-condition and the arm path (≥1)
- CNT_W, 8, event counter and threshold width (≥2)

- CLK  in  1  clock, all flops rising-edge
- RSTB  in  1  reset, asynchronous, active-low; one clock; RSTB low clears every flop
- en  in  1  monitor enable
- clr  in  1  synchronous clear of counter and FSM
- a  in  CH  pair-condition operand A per channel
- b  in  CH  pair-condition operand B per channel
- arm  in  CH  per-channel arm input
- blk0  in  CH  block input 0 per channel, active-high, not delayed
- blk1  in  CH  block input 1 per channel, active-high, not delayed
- thresh  in  CNT_W  alarm threshold; 0 disables the alarm
- hit  out  CH  registered per-channel hit
- cnt  out  CNT_W  event count
- state  out  2  FSM state: 0 IDLE, 1 COUNT, 2 ALERT
- alarm  out  1  sticky alarm, high only in ALERT

## Operation
- Per channel c: g[c] = a[c] & b[c]. g and arm each pass through DEPTH flops, giving gd[c] and ad[c].
- Next hit[c] = ~(blk0[c] | blk1[c]) & ad[c] & ~gd[c]. hit is registered every cycle, independent of en and FSM state.
- any_hit = OR of the registered hit bits.
- FSM:
  - IDLE: cnt holds. en=1 → COUNT.
  - COUNT: cnt increments by 1 on each cycle with any_hit=1. It saturates at 2^CNT_W−1 and never wraps.
  - COUNT → ALERT when registered cnt ≥ thresh and thresh ≠ 0.
  - COUNT → IDLE when en=0. cnt holds. The ALERT check takes priority over the en check.
  - ALERT: cnt frozen, alarm=1. en has no effect. ALERT is left only through clr or reset.
- clr=1, any state: cnt←0 and state←IDLE on the next edge. clr wins over an increment or a transition in the same cycle. Delay lines and hit are not cleared.
- Changing thresh while in COUNT takes effect on the next comparison. If thresh drops to ≤ cnt, the FSM enters ALERT on the next edge.
- Reset values: hit=0, cnt=0, state=IDLE (0), alarm=0, all delay-line flops=0.

## Timing
- a/b/arm sampled at edge t reach gd/ad after edge t+DEPTH−1, so they are visible to hit logic during cycle t+DEPTH−1.
- hit registers at edge t+DEPTH, using blk0/blk1 as sampled at that same edge.
- Total latency from a/b/arm to hit: DEPTH edges.
- any_hit=1 after edge k increments cnt at edge k+1, provided state is COUNT at that edge.
- cnt reaching thresh at edge k gives state=ALERT and alarm=1 after edge k+1.
- en=1 sampled at edge k in IDLE gives state=COUNT after edge k. The first countable hit is the one registered before edge k+1.
- RSTB assertion mid-count clears all outputs immediately, without waiting for a clock. Deassertion is synchronised externally and meets recovery/removal timing at CLK.

## Test plan
- Reset: with RSTB low, drive all inputs to 1 and toggle CLK → hit=0, cnt=0, state=0, alarm=0. Release RSTB with all inputs 0 → outputs stay 0.
- Latency (CH=4, DEPTH=2): arm[1]=1 and a=b=0 for one cycle at edge t, blk=0 → hit=4'b0010 for exactly the one cycle after edge t+2. Repeat with a[1]=b[1]=1 in the same cycle → hit stays 0.
- Block: same stimulus, with blk1[1]=1 sampled at edge t+2 only → hit[1]=0. With blk1[1]=1 at edge t+1 only → hit[1]=1.
- Count/alarm: en=1, thresh=3, three hit cycles on different channels → cnt goes 1, 2, 3; alarm=1 one edge after cnt=3. Further hits → cnt stays 3. en=0 → alarm stays 1.
- Saturation and disable (CNT_W=2): thresh=0, continuous hits for 6 cycles → cnt=3 held, state=1, alarm=0.
- Clear priority: in COUNT with cnt=2 and thresh=3, clr=1 in the same cycle a hit would increment → cnt=0, state=0. Afterwards en=0 → state stays 0 and hits are not counted.
